fixed_prio_burst_mux: RTL and testbench
=======================================

// Module: fixed_prio_burst_mux
// PURPOSE
//  - N-input valid/ready burst multiplexer. Feeds one shared sink from REQ_WIDTH requesters.
//  - Arbitrates with a fixed-priority pick (lowest index wins) and locks the grant for the whole burst.
//  - Releases the grant after the beat carrying in_last is accepted.
//  - Sits directly downstream of the request vector and upstream of the shared resource.
// PARAMETERS
//  - REQ_WIDTH   8   number of requesters (>=2)
//  - DATA_WIDTH  32  payload width per beat
//  - CNT_WIDTH   8   width of beat counter (saturating)
// PORTS
//  - clk           in   1                     rising-edge clock
//  - rst           in   1                     synchronous, active-high reset
//  - in_valid      in   REQ_WIDTH             per-requester beat valid
//  - in_last       in   REQ_WIDTH             per-requester end-of-burst marker
//  - in_data       in   REQ_WIDTH*DATA_WIDTH  payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  - in_ready      out  REQ_WIDTH             per-requester accept; at most one bit set
//  - out_valid     out  1                     registered beat valid to sink
//  - out_ready     in   1                     sink accept
//  - out_data      out  DATA_WIDTH            registered payload
//  - out_last      out  1                     registered end-of-burst
//  - out_src       out  $clog2(REQ_WIDTH)     index of the requester that owns the current beat
//  - busy          out  1                     1 while in LOCKED state
//  - beat_cnt      out  CNT_WIDTH             beats accepted in the current or last burst; saturates
// BEHAVIOUR
//  - Reset values: state=IDLE, lock=0, in_ready=0, out_valid=0, out_data=0, out_last=0, out_src=0,
//    busy=0, beat_cnt=0.
//  - FSM states: IDLE, LOCKED.
//  - IDLE:
//    - in_ready=0.
//    - If |in_valid, then lock <= in_valid & ~(in_valid-1), i.e. the lowest set bit.
//      out_src and beat_cnt are set to 0 when lock is taken; state goes to LOCKED.
//    - Arbitration costs exactly one bubble cycle.
//  - LOCKED:
//    - in_ready = lock & {REQ_WIDTH{~out_valid | out_ready}}. This is a single output register stage.
//    - Accept = in_valid[g] & in_ready[g], where g is the locked index.
//    - On accept:
//      - out_data/out_last load the selected lane.
//      - out_valid <= 1.
//      - out_src <= g.
//      - beat_cnt++ (saturates at all-ones).
//    - If out_ready & out_valid and no new accept, then out_valid <= 0.
//    - Accept with in_last[g]=1: state <= IDLE and lock <= 0 on the same edge.
//      The output register still drains normally.
//  - Latency: beat accepted at edge k appears on out_* after edge k.
//    - Throughput is 1 beat/cycle within a burst while out_ready=1.
//    - Gap between bursts is 1 cycle (IDLE).
//  - Requester g drops in_valid mid-burst: grant held indefinitely, no re-arbitration.
//    Higher-priority requests wait.
//  - Changes to non-granted in_valid/in_last/in_data are ignored while LOCKED.
//  - Single-beat burst (in_last on first beat): LOCKED lasts exactly one accept cycle.
//  - out_ready=0 with out_valid=1: in_ready=0, and out_* remain stable (valid/data hold rule).
//  - Simultaneous drain + accept: out_valid stays 1 and new data loads.
//  - rst mid-burst: all state cleared on that edge. The pending out beat is dropped; no partial-burst recovery.
//  - Requester data must be held by the source until in_ready; sink must not depend on out_ready for out_valid.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE=1'b0, LOCKED=1'b1) and function onehot2idx(onehot) -> index.
//  - One sub-module, fixed_prio_pick: combinational req -> one-hot gnt, lowest bit highest priority,
//    parameter REQ_WIDTH.
//  - Top level holds FSM, lock register, lane mux (AND-OR on lock), output register, beat counter.
// TESTING
//  - Check in_ready is one-hot-or-zero and out_valid/out_data are stable under backpressure on every cycle.
//  - in_valid=8'b0010_0100, both 3-beat bursts, out_ready=1:
//    - Requester 2 granted; out_src=2 for beats A0..A2.
//    - 1-cycle IDLE gap, then requester 5 for B0..B2.
//    - beat_cnt reads 3 after each burst.
//  - Mid-burst preemption attempt: requester 3 bursting (4 beats); requester 0 raises valid at beat 2.
//    - Requester 3 finishes all 4 beats first.
//    - Then requester 0 is granted.
//  - Backpressure: out_ready=0 for 3 cycles after first beat.
//    - out_valid=1 and out_data held constant.
//    - in_ready=0 during the stall.
//    - No beat lost or duplicated; 5-beat burst delivered in order.
//  - Single-beat bursts from requesters 1,1,1 back-to-back: out_last=1 on each; 2 cycles per beat (bubble).
//  - Reset asserted one cycle after second beat of 4-beat burst.
//    - Next cycle: busy=0, out_valid=0, in_ready=0, beat_cnt=0.
//    - Fresh arbitration after rst deasserts.

Source files
------------

// File: rtl/fixed_prio_burst_mux_pkg.sv
// Shared types and helpers for the fixed-priority burst multiplexer.
// Holds the FSM state encoding and the one-hot to index conversion.
package fixed_prio_burst_mux_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  // Widest request vector onehot2idx can convert.
  localparam int unsigned MaxReqWidth = 64;

  // A zero vector maps to index 0.
  function automatic int unsigned onehot2idx(input logic [MaxReqWidth-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReqWidth; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_prio_pick.sv
// Combinational fixed-priority picker: returns the lowest set request bit as a one-hot grant.
module fixed_prio_pick #(
  parameter int unsigned REQ_WIDTH = 8
) (
  input  logic [REQ_WIDTH-1:0] req,
  output logic [REQ_WIDTH-1:0] gnt
);

  // Subtracting one clears the lowest set bit and sets every bit below it.
  always_comb begin
    gnt = req & ~(req - REQ_WIDTH'(1));
  end

endmodule

// File: rtl/fixed_prio_burst_mux.sv
// Valid/ready burst multiplexer: fixed-priority arbitration, grant locked until the
// beat carrying in_last is accepted, single registered output stage.
module fixed_prio_burst_mux
  import fixed_prio_burst_mux_pkg::*;
#(
  parameter int unsigned REQ_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_WIDTH-1:0]            in_valid,
  input  logic [REQ_WIDTH-1:0]            in_last,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [REQ_WIDTH-1:0]            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [$clog2(REQ_WIDTH)-1:0]    out_src,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            beat_cnt
);

  localparam int unsigned IdxW = $clog2(REQ_WIDTH);

  state_e                 state_q, state_d;
  logic [REQ_WIDTH-1:0]   lock_q, lock_d;
  logic [REQ_WIDTH-1:0]   pick_gnt;
  logic                   lock_take;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_last;
  logic [IdxW-1:0]        lock_idx;

  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_last_q;
  logic [IdxW-1:0]        out_src_q;
  logic [CNT_WIDTH-1:0]   beat_cnt_q;

  fixed_prio_pick #(
    .REQ_WIDTH(REQ_WIDTH)
  ) u_pick (
    .req(in_valid),
    .gnt(pick_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      StIdle: begin
        if (|in_valid) begin
          state_d = StLocked;
          lock_d  = pick_gnt;
        end
      end
      StLocked: begin
        if (accept && sel_last) begin
          state_d = StIdle;
          lock_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: a lane is only offered a slot when the output register is free or draining.
  always_comb begin
    in_ready = '0;
    busy     = 1'b0;
    if (state_q == StLocked) begin
      busy     = 1'b1;
      in_ready = lock_q & {REQ_WIDTH{~out_valid_q | out_ready}};
    end
  end

  always_comb begin
    lock_take = (state_q == StIdle) && (|in_valid);
    accept    = |(in_valid & in_ready);
    sel_data  = '0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
      sel_data = sel_data | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{lock_q[i]}});
    end
    sel_last = |(in_last & lock_q);
    lock_idx = IdxW'(onehot2idx(MaxReqWidth'(lock_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      beat_cnt_q  <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_src_q   <= lock_idx;
        if (!(&beat_cnt_q)) beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (lock_take) begin
        out_src_q  <= '0;
        beat_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    out_src   = out_src_q;
    beat_cnt  = beat_cnt_q;
  end

endmodule

// File: tb/tb_fixed_prio_burst_mux.sv
// Scoreboard bench for fixed_prio_burst_mux: directed burst programs push expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_fixed_prio_burst_mux;

  localparam int unsigned ReqW  = 8;
  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 8;
  localparam int unsigned IdxW  = 3;
  localparam int          MaxCyc = 300;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ReqW-1:0]        in_valid;
  logic [ReqW-1:0]        in_last;
  logic [ReqW*DataW-1:0]  in_data;
  logic [ReqW-1:0]        in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [DataW-1:0]       out_data;
  logic                   out_last;
  logic [IdxW-1:0]        out_src;
  logic                   busy;
  logic [CntW-1:0]        beat_cnt;

  fixed_prio_burst_mux #(
    .REQ_WIDTH (ReqW),
    .DATA_WIDTH(DataW),
    .CNT_WIDTH (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_src  (out_src),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IdxW-1:0]  src;
    logic [DataW-1:0] data;
    logic             last;
    logic [CntW-1:0]  cnt;
    int               gap;   // cycles since previous output beat; 0 = first beat of a test
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DataW-1:0] mk_data(input int t, input int l, input int b,
                                               input int k);
    return {8'(t), 4'(l), 4'(b), 16'(k)};
  endfunction

  task automatic push_burst(input int t, input int l, input int b, input int nbeats,
                            input int len, input int first_gap);
    exp_t e;
    for (int k = 0; k < nbeats; k++) begin
      e.src  = IdxW'(l);
      e.data = mk_data(t, l, b, k);
      e.last = (k == len - 1);
      e.cnt  = CntW'(k + 1);
      e.gap  = (k == 0) ? first_gap : 1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each handshake.
  logic             prev_stall = 1'b0;
  logic [DataW-1:0] prev_data  = '0;
  int               last_hs    = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    chk("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
    if (prev_stall) begin
      chk("stall_valid_hold", 64'(out_valid), 64'd1);
      chk("stall_data_hold", 64'(out_data), 64'(prev_data));
    end
    if (out_valid && !out_ready && !rst) chk("stall_in_ready", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h src %0d, expected no beat", out_data,
                 out_src);
      end else begin
        e = exp_q.pop_front();
        chk("beat_src", 64'(out_src), 64'(e.src));
        chk("beat_data", 64'(out_data), 64'(e.data));
        chk("beat_last", 64'(out_last), 64'(e.last));
        chk("beat_cnt", 64'(beat_cnt), 64'(e.cnt));
        if (e.gap != 0) chk("beat_gap", 64'(cyc - last_hs), 64'(e.gap));
      end
      last_hs = cyc;
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
  end

  // Burst program: per-lane burst length, burst count and start cycle.
  int lane_len[ReqW];
  int lane_nb[ReqW];
  int lane_start[ReqW];
  int lane_bur[ReqW];
  int lane_beat[ReqW];
  int test_id;
  int stall_s;
  int stall_n;
  int rst_at;

  task automatic clear_prog(input int t);
    test_id = t;
    stall_s = 0;
    stall_n = 0;
    rst_at  = -1;
    for (int l = 0; l < ReqW; l++) begin
      lane_len[l]   = 1;
      lane_nb[l]    = 0;
      lane_start[l] = 0;
      lane_bur[l]   = 0;
      lane_beat[l]  = 0;
    end
  endtask

  task automatic add_lane(input int l, input int len, input int nb, input int start);
    lane_len[l]   = len;
    lane_nb[l]    = nb;
    lane_start[l] = start;
  endtask

  function automatic bit all_done();
    for (int l = 0; l < ReqW; l++) begin
      if (lane_bur[l] < lane_nb[l]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_prog();
    int              c;
    logic [ReqW-1:0] acc;
    c = 0;
    while (!all_done() && c < MaxCyc) begin
      rst = (c == rst_at);
      if (rst_at >= 0 && c == rst_at + 1) begin
        for (int l = 0; l < ReqW; l++) lane_bur[l] = lane_nb[l];
      end
      out_ready = !(c >= stall_s && c < stall_s + stall_n);
      for (int l = 0; l < ReqW; l++) begin
        if (lane_bur[l] < lane_nb[l] && c >= lane_start[l]) begin
          in_valid[l]                = 1'b1;
          in_last[l]                 = (lane_beat[l] == lane_len[l] - 1);
          in_data[l*DataW +: DataW]  = mk_data(test_id, l, lane_bur[l], lane_beat[l]);
        end else begin
          in_valid[l] = 1'b0;
          in_last[l]  = 1'b0;
        end
      end
      @(negedge clk);
      acc = in_valid & in_ready;
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);
        chk("post_rst_beat_cnt", 64'(beat_cnt), 64'd0);
      end
      @(posedge clk);
      #1;
      if (c != rst_at) begin
        for (int l = 0; l < ReqW; l++) begin
          if (acc[l]) begin
            lane_beat[l]++;
            if (lane_beat[l] == lane_len[l]) begin
              lane_beat[l] = 0;
              lane_bur[l]++;
            end
          end
        end
      end
      c++;
    end
    if (c >= MaxCyc) begin
      checks++;
      errors++;
      $display("FAIL prog_timeout: test %0d still running after %0d cycles, expected done",
               test_id, c);
    end
    in_valid  = '0;
    in_last   = '0;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    clear_prog(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Requesters 2 and 5 together: 2 wins, one bubble, then 5.
    clear_prog(1);
    add_lane(2, 3, 1, 0);
    add_lane(5, 3, 1, 0);
    push_burst(1, 2, 0, 3, 3, 0);
    push_burst(1, 5, 0, 3, 3, 2);
    run_prog();

    // Requester 0 rises mid-burst of requester 3 and must wait.
    clear_prog(2);
    add_lane(3, 4, 1, 0);
    add_lane(0, 2, 1, 3);
    push_burst(2, 3, 0, 4, 4, 0);
    push_burst(2, 0, 0, 2, 2, 2);
    run_prog();

    // Sink stalls for 3 cycles right after the first beat of a 5-beat burst.
    clear_prog(3);
    add_lane(6, 5, 1, 0);
    stall_s = 2;
    stall_n = 3;
    push_burst(3, 6, 0, 5, 5, 0);
    run_prog();

    // Three back-to-back single-beat bursts from requester 1.
    clear_prog(4);
    add_lane(1, 1, 3, 0);
    push_burst(4, 1, 0, 1, 1, 0);
    push_burst(4, 1, 1, 1, 1, 2);
    push_burst(4, 1, 2, 1, 1, 2);
    run_prog();

    // Reset one cycle after the second beat of a 4-beat burst; only two beats emerge.
    clear_prog(5);
    add_lane(4, 4, 1, 0);
    rst_at = 3;
    push_burst(5, 4, 0, 2, 4, 0);
    run_prog();

    // Fresh arbitration after reset.
    clear_prog(6);
    add_lane(7, 2, 1, 0);
    add_lane(4, 1, 1, 0);
    push_burst(6, 4, 0, 1, 1, 0);
    push_burst(6, 7, 0, 2, 2, 2);
    run_prog();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
